div32_by16_seq: RTL and testbench
=================================

DIV32_BY16_SEQ -- requirements
Module: div32_by16_seq

Interface
REQ-001 The block SHALL have parameter DW, default 16, giving divisor/quotient/remainder width; the dividend is 2*DW bits.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and is the reset, asynchronous and active-low.
REQ-004 The port in_valid SHALL be an input, 1 bit wide, and signals that an operand pair is offered.
REQ-005 The port in_ready SHALL be an output, 1 bit wide, and signals that the block accepts operands.
REQ-006 The port dividend SHALL be an input, 2*DW bits wide, carrying the unsigned dividend.
REQ-007 The port divisor SHALL be an input, DW bits wide, carrying the unsigned divisor.
REQ-008 The port out_valid SHALL be an output, 1 bit wide, and signals that a result is held.
REQ-009 The port out_ready SHALL be an input, 1 bit wide, and signals that the consumer takes the result.
REQ-010 The port quotient SHALL be an output, DW bits wide, carrying the unsigned quotient.
REQ-011 The port remainder SHALL be an output, DW bits wide, carrying the unsigned remainder.
REQ-012 The port div_zero SHALL be an output, 1 bit wide, and is set when the divisor was 0.
REQ-013 The port overflow SHALL be an output, 1 bit wide, and is set when the quotient does not fit in DW bits.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Acceptance SHALL occur on a rising edge with in_valid && in_ready; operands are registered internally, so later input changes have no effect.
REQ-016 On acceptance with divisor==0: next state DONE, quotient={DW{1}}, remainder=dividend[DW-1:0], div_zero=1, overflow=0.
REQ-017 Else on acceptance with dividend[2DW-1:DW] >= divisor: next state DONE, quotient={DW{1}}, remainder=0, overflow=1, div_zero=0.
REQ-018 Else: next state BUSY, partial remainder=dividend[2DW-1:DW], shift register=dividend[DW-1:0], iteration counter=0, both flags 0.
REQ-019 Each BUSY cycle SHALL perform one restoring step: form a (DW+1)-bit trial {rem,msb of shift}; if trial >= divisor, rem=trial-divisor and the quotient bit is 1, else rem=trial[DW-1:0] and the quotient bit is 0; the quotient bit shifts in at the LSB.
REQ-020 After exactly DW BUSY steps (counter reaching DW-1 at the step edge), the next state SHALL be DONE; normal latency is DW+1 rising edges from the acceptance edge to first out_valid=1 (17 for DW=16); error latency is 1 edge.
REQ-021 In DONE, quotient, remainder and the flags SHALL hold stable until a rising edge with out_ready=1, which returns the FSM to IDLE; no operand is accepted on that same edge.
REQ-022 For valid cases, results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor.
REQ-023 While in IDLE or BUSY, outputs quotient/remainder/flags SHALL retain their last values; only out_valid qualifies them.

Reset
REQ-024 Asserting rst_n low at any time, including mid-BUSY or in DONE, SHALL immediately force state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0, counter=0; the in-flight operation is discarded.
REQ-025 After rst_n deasserts, the first rising edge SHALL be able to accept an operand.

Structure
REQ-026 A shared package div_pkg SHALL hold the FSM state enum (IDLE/BUSY/DONE) and the DW default constant.
REQ-027 The single restoring step (trial compare/subtract, quotient bit out) SHALL be one combinational sub-module, div_step, instantiated once.

Verification
REQ-028 The bench SHALL drive 100 / 7; the required response is quotient=14, remainder=2, flags 0, and out_valid exactly 17 edges after acceptance.
REQ-029 The bench SHALL drive 0xFFFE0001 / 0xFFFF; the required response is quotient=0xFFFF, remainder=0, flags 0.
REQ-030 The bench SHALL drive 0x00012345 / 0; the required response is div_zero=1, quotient=0xFFFF, remainder=0x2345, with out_valid on the next edge.
REQ-031 The bench SHALL drive 0x00010000 / 1; the required response is overflow=1, quotient=0xFFFF, remainder=0.
REQ-032 The bench SHALL complete 1000 / 3 while holding out_ready=0 for 5 cycles; outputs must stay at 333/1, in_ready must stay 0, and IDLE must be reached one edge after out_ready=1.
REQ-033 The bench SHALL pulse rst_n low at BUSY step 8 and then issue 50 / 5; the required response is all outputs at reset values, followed by a clean result of 10/0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential 2*DW / DW restoring divider.
package div_pkg;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] rem_i,
  input  logic          msb_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW-1:0] rem_o,
  output logic          qbit_o
);
  logic [DW:0] trial;

  always_comb begin
    trial  = {rem_i, msb_i};
    qbit_o = (trial >= {1'b0, divisor_i});
    // rem_i < divisor_i guarantees the difference fits in DW bits, so modular subtraction is exact.
    rem_o  = qbit_o ? (trial[DW-1:0] - divisor_i) : trial[DW-1:0];
  end
endmodule

// File: rtl/div32_by16_seq.sv
// Sequential unsigned 2*DW by DW divider, one quotient bit per cycle, valid/ready on both sides.
module div32_by16_seq
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero,
  output logic            overflow
);
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  state_e        state_q, state_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [DW-1:0] remd_q, remd_d;
  logic          dz_q, dz_d;
  logic          ov_q, ov_d;

  logic [DW-1:0] step_rem;
  logic          step_qbit;

  div_step #(.DW(DW)) u_step (
    .rem_i     (rem_q),
    .msb_i     (shift_q[DW-1]),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      shift_q <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  // Visible results live in separate registers so they hold steady while a new division runs.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvsr_d = divisor;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            remd_d  = dividend[DW-1:0];
            dz_d    = 1'b1;
            ov_d    = 1'b0;
          end else if (dividend[2*DW-1:DW] >= divisor) begin
            state_d = DONE;
            quot_d  = '1;
            remd_d  = '0;
            dz_d    = 1'b0;
            ov_d    = 1'b1;
          end else begin
            state_d = BUSY;
            rem_d   = dividend[2*DW-1:DW];
            shift_d = dividend[DW-1:0];
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        rem_d   = step_rem;
        shift_d = {shift_q[DW-2:0], step_qbit};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = DONE;
          quot_d  = {shift_q[DW-2:0], step_qbit};
          remd_d  = step_rem;
          dz_d    = 1'b0;
          ov_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = remd_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;
endmodule

// File: tb/tb_div32_by16_seq.sv
// Directed bench for div32_by16_seq: hand-computed quotients, latencies, backpressure and reset.
module tb_div32_by16_seq;
  localparam int unsigned DW = 16;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_zero;
  logic            overflow;

  int errors = 0;
  int checks = 0;
  int edges;

  div32_by16_seq #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one operand pair, scramble inputs after the accepting edge, count edges to out_valid.
  task automatic run_op(input logic [2*DW-1:0] dvd, input logic [DW-1:0] dvs);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 16'h0003;
    edges    = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_flags", {30'd0, div_zero, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7 = 14 r 2
    run_op(32'd100, 16'd7);
    check("d100_latency", 32'(edges), 32'd17);
    check("d100_quotient", 32'(quotient), 32'd14);
    check("d100_remainder", 32'(remainder), 32'd2);
    check("d100_flags", {30'd0, div_zero, overflow}, 32'd0);
    check("d100_in_ready", 32'(in_ready), 32'd0);
    pop();
    check("d100_pop_in_ready", 32'(in_ready), 32'd1);
    check("d100_pop_out_valid", 32'(out_valid), 32'd0);

    // 0xFFFE0001 / 0xFFFF = 0xFFFF r 0
    run_op(32'hFFFE_0001, 16'hFFFF);
    check("max_latency", 32'(edges), 32'd17);
    check("max_quotient", 32'(quotient), 32'h0000_FFFF);
    check("max_remainder", 32'(remainder), 32'd0);
    check("max_flags", {30'd0, div_zero, overflow}, 32'd0);
    pop();

    // divide by zero
    run_op(32'h0001_2345, 16'd0);
    check("dz_latency", 32'(edges), 32'd1);
    check("dz_div_zero", 32'(div_zero), 32'd1);
    check("dz_overflow", 32'(overflow), 32'd0);
    check("dz_quotient", 32'(quotient), 32'h0000_FFFF);
    check("dz_remainder", 32'(remainder), 32'h0000_2345);
    pop();

    // overflow: high half 1 >= divisor 1
    run_op(32'h0001_0000, 16'd1);
    check("ov_latency", 32'(edges), 32'd1);
    check("ov_overflow", 32'(overflow), 32'd1);
    check("ov_div_zero", 32'(div_zero), 32'd0);
    check("ov_quotient", 32'(quotient), 32'h0000_FFFF);
    check("ov_remainder", 32'(remainder), 32'd0);
    pop();

    // 1000 / 3 = 333 r 1 with the consumer stalling for 5 cycles, new operand offered meanwhile
    run_op(32'd1000, 16'd3);
    check("bp_latency", 32'(edges), 32'd17);
    @(negedge clk);
    dividend = 32'd77;
    divisor  = 16'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_quotient", 32'(quotient), 32'd333);
      check("bp_hold_remainder", 32'(remainder), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_no_accept_on_pop", 32'(in_ready), 32'd1);
    check("bp_idle_retains_quotient", 32'(quotient), 32'd333);

    // reset in the middle of a BUSY run, after step 8
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 16'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_quotient", 32'(quotient), 32'd0);
    check("mr_remainder", 32'(remainder), 32'd0);
    check("mr_flags", {30'd0, div_zero, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd50, 16'd5);
    check("post_rst_latency", 32'(edges), 32'd17);
    check("post_rst_quotient", 32'(quotient), 32'd10);
    check("post_rst_remainder", 32'(remainder), 32'd0);
    check("post_rst_flags", {30'd0, div_zero, overflow}, 32'd0);
    pop();
    check("post_rst_idle", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
